// File: rtl/shake_squeeze_pkg.sv
// Shared types and constants for the SHAKE squeeze stage that follows the
// Keccak-f[1600] core.
package shake_pkg;

    localparam int STATE_W             = 1600;
    localparam int LANE_W              = 64;
    localparam int SHAKE128_RATE_LANES = 21;
    localparam int SHAKE256_RATE_LANES = 17;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PERM,
        EMIT,
        REQ
    } sqz_state_e;

endpackage

// File: rtl/shake_squeeze_if.sv
// Output word stream of the squeeze stage: one 64-bit lane per valid/ready
// handshake, with word_last marking the final word of a session.
interface shake_squeeze_if;
    import shake_pkg::*;

    lane_t word_out;
    logic  word_valid;
    logic  word_ready;
    logic  word_last;

    modport master (output word_out, word_valid, word_last, input word_ready);
    modport slave  (input word_out, word_valid, word_last, output word_ready);
endinterface

// File: rtl/shake_squeeze.sv
// Captures the rate lanes of each permutation and streams them out until
// out_len words are delivered. Define SHAKE_SQZ_PREFETCH_EN for ping-pong prefetch.
module shake_squeeze
    import shake_pkg::*;
#(
    parameter int RATE_LANES = SHAKE128_RATE_LANES,
    parameter int LEN_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   out_len,
    input  logic               perm_valid,
    input  logic [STATE_W-1:0] perm_state,
    output logic               perm_req,
    output logic               busy,
    output logic               done,
    shake_squeeze_if.master    sq
);

    localparam int               IDX_W    = $clog2(RATE_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);
    localparam logic [LEN_W-1:0] RATE_LEN = LEN_W'(RATE_LANES);

    sqz_state_e       state;
    logic [LEN_W-1:0] remaining;
    logic [IDX_W-1:0] lane_idx;
    logic             word_valid_q;
    logic             perm_valid_q;
    logic             valid_rise;
    logic             capture;
    logic             handshake;

    // Capacity lanes never leave the core; folded here only to mark them consumed.
    logic unused_capacity;
    assign unused_capacity = ^perm_state[STATE_W-1:RATE_LANES*LANE_W];

    assign valid_rise = perm_valid && !perm_valid_q;
    assign handshake  = word_valid_q && sq.word_ready;

    assign sq.word_valid = word_valid_q;
    assign sq.word_last  = word_valid_q && (remaining == LEN_W'(1));
    assign busy          = (state != IDLE);

`ifdef SHAKE_SQZ_PREFETCH_EN
    logic             rd_sel;
    logic             wr_sel;
    logic [1:0]       full;
    logic             outstanding;
    logic             req_due;
    logic [LEN_W-1:0] uncaptured;

    assign capture = outstanding && valid_rise;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        lane_t lanes_q [RATE_LANES];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < RATE_LANES; i++) lanes_q[i] <= '0;
            end else if (capture && (wr_sel == 1'(b))) begin
                for (int i = 0; i < RATE_LANES; i++) lanes_q[i] <= perm_state[i*LANE_W +: LANE_W];
            end
        end
    end

    assign sq.word_out = rd_sel ? g_bank[1].lanes_q[lane_idx] : g_bank[0].lanes_q[lane_idx];
`else
    lane_t lanes_q [RATE_LANES];

    assign capture = (state == WAIT_PERM) && valid_rise;

    // NOTE: the buffer is a register file, not a RAM, so it can take the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RATE_LANES; i++) lanes_q[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < RATE_LANES; i++) lanes_q[i] <= perm_state[i*LANE_W +: LANE_W];
        end
    end

    assign sq.word_out = lanes_q[lane_idx];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            lane_idx     <= '0;
            word_valid_q <= 1'b0;
            perm_req     <= 1'b0;
            done         <= 1'b0;
            perm_valid_q <= 1'b0;
`ifdef SHAKE_SQZ_PREFETCH_EN
            rd_sel       <= 1'b0;
            wr_sel       <= 1'b0;
            full         <= '0;
            outstanding  <= 1'b0;
            req_due      <= 1'b0;
            uncaptured   <= '0;
`endif
        end else begin
            perm_valid_q <= perm_valid;
            // NOTE: pulse outputs default low each cycle; later assignments win.
            done         <= 1'b0;
            perm_req     <= 1'b0;
`ifdef SHAKE_SQZ_PREFETCH_EN
            if (capture) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
                outstanding  <= 1'b0;
                if (uncaptured > RATE_LEN) begin
                    uncaptured <= uncaptured - RATE_LEN;
                    req_due    <= 1'b1;
                end else begin
                    uncaptured <= '0;
                end
            end
            // Only ask for another block once a bank is free to receive it.
            if (req_due && !outstanding && (full != 2'b11)) begin
                perm_req    <= 1'b1;
                outstanding <= 1'b1;
                req_due     <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= out_len;
                        lane_idx  <= '0;
                        if (out_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= WAIT_PERM;
`ifdef SHAKE_SQZ_PREFETCH_EN
                            uncaptured  <= out_len;
                            outstanding <= 1'b1;
                            rd_sel      <= 1'b0;
                            wr_sel      <= 1'b0;
                            full        <= '0;
                            req_due     <= 1'b0;
`endif
                        end
                    end
                end
                WAIT_PERM: begin
`ifdef SHAKE_SQZ_PREFETCH_EN
                    if (capture || full[rd_sel]) begin
`else
                    if (capture) begin
`endif
                        state        <= EMIT;
                        lane_idx     <= '0;
                        word_valid_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        remaining <= remaining - LEN_W'(1);
                        lane_idx  <= lane_idx + IDX_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state        <= IDLE;
                            word_valid_q <= 1'b0;
                            done         <= 1'b1;
`ifdef SHAKE_SQZ_PREFETCH_EN
                            full        <= '0;
                            req_due     <= 1'b0;
                            outstanding <= 1'b0;
`endif
                        end else if (lane_idx == LAST_IDX) begin
`ifdef SHAKE_SQZ_PREFETCH_EN
                            full[rd_sel] <= 1'b0;
                            rd_sel       <= ~rd_sel;
                            lane_idx     <= '0;
                            // A bank landing on this same edge counts as ready.
                            if (!(full[~rd_sel] || (capture && (wr_sel != rd_sel)))) begin
                                state        <= WAIT_PERM;
                                word_valid_q <= 1'b0;
                            end
`else
                            state        <= REQ;
                            word_valid_q <= 1'b0;
                            perm_req     <= 1'b1;
`endif
                        end
                    end
                end
                REQ:     state <= WAIT_PERM;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_squeeze.sv
// Scoreboard bench for shake_squeeze: a model core supplies numbered blocks,
// expected words are queued per session and a monitor checks each handshake.
module tb_shake_squeeze;
    import shake_pkg::*;

    localparam int R        = SHAKE128_RATE_LANES;
    localparam int LW       = 16;
    localparam int CORE_LAT = 30;
    localparam int DROP_DLY = 4;

    typedef struct {
        lane_t w;
        logic  last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LW-1:0]      out_len;
    logic               perm_valid;
    logic [STATE_W-1:0] perm_state;
    logic               perm_req;
    logic               busy;
    logic               done;

    shake_squeeze_if sq ();

    shake_squeeze #(.RATE_LANES(R), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out_len   (out_len),
        .perm_valid(perm_valid),
        .perm_state(perm_state),
        .perm_req  (perm_req),
        .busy      (busy),
        .done      (done),
        .sq        (sq)
    );

    initial forever #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    int          req_cnt = 0;
    int          done_cnt = 0;
    int          hs_cnt = 0;
    int          sess_base = 0;
    bit          bp_mode = 1'b0;
    int          core_kick = 0;
    logic [15:0] core_seed = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Seed 0 block 0 carries the published SHAKE128 output lanes in its first four lanes.
    function automatic lane_t make_lane(input logic [15:0] seed, input int blk, input int lane);
        lane_t kv [4];
        kv[0] = 64'hecfcfdba740b56bc;
        kv[1] = 64'he81da07d3389ef6b;
        kv[2] = 64'h6ccbe3e70953c633;
        kv[3] = 64'h16beaa63a2f5f9ff;
        if (seed == 16'd0 && blk == 0 && lane < 4) return kv[lane];
        return {seed, 8'hA5, 8'(blk), 16'h5AC3, 8'(lane), 8'h3C};
    endfunction

    function automatic logic [STATE_W-1:0] make_state(input logic [15:0] seed, input int blk);
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s[i*64 +: 64] = make_lane(seed, blk, i);
        return s;
    endfunction

    // Model core: keeps valid high a few cycles past each request, then
    // delivers the next numbered block after CORE_LAT cycles.
    initial begin : core
        int blk, drop, lat, seen;
        perm_valid = 1'b0;
        perm_state = '0;
        blk = 0; drop = 0; lat = 0; seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                perm_valid = 1'b0;
                drop = 0;
                lat = 0;
            end else if (core_kick != seen) begin
                seen = core_kick;
                blk = -1;
                perm_valid = 1'b0;
                drop = 0;
                lat = 2;
            end else begin
                if (perm_req) drop = DROP_DLY;
                if (drop > 0) begin
                    drop--;
                    if (drop == 0) begin
                        perm_valid = 1'b0;
                        lat = CORE_LAT;
                    end
                end else if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        blk++;
                        perm_state = make_state(core_seed, blk);
                        perm_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: drives ready, checks every handshake and stall stability.
    initial begin : monitor
        logic  stall, req_due, done_due;
        lane_t prev_w;
        exp_t  e;
        stall = 1'b0; req_due = 1'b0; done_due = 1'b0; prev_w = '0;
        sq.word_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0; req_due = 1'b0; done_due = 1'b0;
                continue;
            end
            if (perm_req) req_cnt++;
            if (done) done_cnt++;
            if (done_due) check("done_after_last", 64'(done), 64'd1);
            if (req_due) check("perm_req_latency", 64'(perm_req), 64'd1);
            done_due = 1'b0;
            req_due  = 1'b0;
            if (stall) begin
                check("stall_valid", 64'(sq.word_valid), 64'd1);
                check("stall_word", sq.word_out, prev_w);
            end
            sq.word_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            stall  = sq.word_valid && !sq.word_ready;
            prev_w = sq.word_out;
            if (sq.word_valid && sq.word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h, expected no word", sq.word_out);
                end else begin
                    e = exp_q.pop_front();
                    check("word", sq.word_out, e.w);
                    check("word_last", 64'(sq.word_last), 64'(e.last));
                    done_due = e.last;
`ifndef SHAKE_SQZ_PREFETCH_EN
                    req_due = !e.last && (((hs_cnt - sess_base) % R) == R - 1);
`endif
                end
                hs_cnt++;
            end
        end
    end

    task automatic kick_session(input logic [15:0] seed, input int len);
        for (int w = 0; w < len; w++) exp_q.push_back('{make_lane(seed, w / R, w % R), (w == len - 1)});
        @(negedge clk);
        sess_base = hs_cnt;
        core_seed = seed;
        core_kick++;
        start     = 1'b1;
        out_len   = LW'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_session(input string name, input logic [15:0] seed, input int len,
                               input bit bp, input bit poke_start);
        int req0, done0, hs0, cyc;
        bp_mode = bp;
        req0 = req_cnt; done0 = done_cnt; hs0 = hs_cnt;
        kick_session(seed, len);
        cyc = 0;
        while (done_cnt == done0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (poke_start && cyc == 10) begin
                start   = 1'b1;
                out_len = LW'(5);
            end else begin
                start = 1'b0;
            end
        end
        if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, cyc);
            exp_q.delete();
        end
        @(negedge clk);
        check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_words"}, 64'(hs_cnt - hs0), 64'(len));
        check({name, "_perm_req_count"}, 64'(req_cnt - req0), 64'((len - 1) / R));
        check({name, "_done_count"}, 64'(done_cnt - done0), 64'd1);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_word_valid"}, 64'(sq.word_valid), 64'd0);
        check({name, "_word_last"}, 64'(sq.word_last), 64'd0);
        check({name, "_word_out"}, sq.word_out, 64'd0);
        check({name, "_perm_req"}, 64'(perm_req), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin : stimulus
        int req0, done0, hs0, cyc;
        rst = 1'b1;
        start = 1'b0;
        out_len = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_session("known_vector", 16'd0, 4, 1'b0, 1'b0);
        run_session("one_block", 16'd1, R, 1'b0, 1'b0);
        run_session("block_plus_one", 16'd2, R + 1, 1'b0, 1'b0);
        run_session("multi_block", 16'd3, 50, 1'b0, 1'b0);
        run_session("backpressure", 16'd3, 30, 1'b1, 1'b1);

        // Zero length: done one cycle after start, nothing else moves.
        bp_mode = 1'b0;
        req0 = req_cnt; hs0 = hs_cnt;
        @(negedge clk);
        start   = 1'b1;
        out_len = '0;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'd0);
        repeat (5) begin
            @(negedge clk);
            check("zero_busy_stays", 64'(busy), 64'd0);
        end
        check("zero_words", 64'(hs_cnt - hs0), 64'd0);
        check("zero_perm_req", 64'(req_cnt - req0), 64'd0);

        // Reset in the middle of emission.
        done0 = done_cnt; hs0 = hs_cnt;
        kick_session(16'd5, R);
        cyc = 0;
        while ((hs_cnt - hs0) < 5 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) begin
            checks++;
            errors++;
            $display("FAIL reset_mid_timeout: got %0d words, expected 5", hs_cnt - hs0);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mid_no_done", 64'(done_cnt - done0), 64'd0);
        run_session("after_reset", 16'd6, 3, 1'b0, 1'b0);
        run_session("two_blocks", 16'd7, 2 * R, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
